// File: rtl/mult_div_unit.sv
// Iterative 32-bit signed multiply (radix-2 Booth) and restoring divide with Hi/Lo result registers.
// Optional MULTDIV_DIVZERO_EXC_EN: a divide by zero skips iteration and raises a one-cycle div_zero pulse.
module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_zero
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MULT   = 2'd1,
        DIV    = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t      state_r, state_s;
    logic [4:0]  count_r;
    logic        op_r, neg_q_r, neg_r_r, dz_pend_r;
    logic [32:0] acc_hi_r;
    logic [31:0] acc_lo_r, m_r;
    logic        q_m1_r;
    logic        busy_r, done_r, div_zero_r;
    logic [31:0] hi_r, lo_r;

    logic        accept_s, b_zero_s;
    logic [32:0] booth_sum_s;
    logic [32:0] rem_shift_s;
    logic [33:0] trial_s;
    logic [31:0] res_hi_s, res_lo_s;

    assign accept_s = start && ((state_r == IDLE) || (state_r == FINISH));

`ifdef MULTDIV_DIVZERO_EXC_EN
    assign b_zero_s = op && (b == 32'd0);
`else
    assign b_zero_s = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE, FINISH: begin
                if (start) begin
                    if (b_zero_s) begin
                        state_s = FINISH;
                    end else if (op) begin
                        state_s = DIV;
                    end else begin
                        state_s = MULT;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            MULT, DIV: begin
                if (count_r == 5'd31) begin
                    state_s = FINISH;
                end else begin
                    state_s = state_r;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Iteration step datapath and final sign correction
    always_comb begin
        case ({acc_lo_r[0], q_m1_r})
            2'b01:   booth_sum_s = acc_hi_r + {m_r[31], m_r};
            2'b10:   booth_sum_s = acc_hi_r - {m_r[31], m_r};
            default: booth_sum_s = acc_hi_r;
        endcase
        rem_shift_s = {acc_hi_r[31:0], acc_lo_r[31]};
        trial_s     = {1'b0, rem_shift_s} - {2'b00, m_r};
        if (op_r) begin
            res_lo_s = neg_q_r ? (32'd0 - acc_lo_r) : acc_lo_r;
            res_hi_s = neg_r_r ? (32'd0 - acc_hi_r[31:0]) : acc_hi_r[31:0];
        end else begin
            res_lo_s = acc_lo_r;
            res_hi_s = acc_hi_r[31:0];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand latch and iteration registers
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r   <= 5'd0;
            op_r      <= 1'b0;
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
            dz_pend_r <= 1'b0;
            acc_hi_r  <= 33'd0;
            acc_lo_r  <= 32'd0;
            m_r       <= 32'd0;
            q_m1_r    <= 1'b0;
        end else if (accept_s) begin
            count_r   <= 5'd0;
            op_r      <= op;
            dz_pend_r <= b_zero_s;
            acc_hi_r  <= 33'd0;
            q_m1_r    <= 1'b0;
            neg_q_r   <= a[31] ^ b[31];
            neg_r_r   <= a[31];
            if (op) begin
                acc_lo_r <= a[31] ? (32'd0 - a) : a;
                m_r      <= b[31] ? (32'd0 - b) : b;
            end else begin
                acc_lo_r <= b;
                m_r      <= a;
            end
        end else if (state_r == MULT) begin
            count_r  <= count_r + 5'd1;
            acc_hi_r <= {booth_sum_s[32], booth_sum_s[32:1]};
            acc_lo_r <= {booth_sum_s[0], acc_lo_r[31:1]};
            q_m1_r   <= acc_lo_r[0];
        end else if (state_r == DIV) begin
            count_r <= count_r + 5'd1;
            // A non-negative trial means the divisor fits: keep the difference, quotient bit 1
            if (!trial_s[33]) begin
                acc_hi_r <= trial_s[32:0];
                acc_lo_r <= {acc_lo_r[30:0], 1'b1};
            end else begin
                acc_hi_r <= rem_shift_s;
                acc_lo_r <= {acc_lo_r[30:0], 1'b0};
            end
        end else begin
            count_r <= count_r;
        end
    end

    // Registered status outputs and Hi/Lo result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
            hi_r       <= 32'd0;
            lo_r       <= 32'd0;
        end else begin
            busy_r     <= (state_r == MULT) || (state_r == DIV);
            done_r     <= (state_r == FINISH);
            div_zero_r <= (state_r == FINISH) && dz_pend_r;
            if ((state_r == FINISH) && !dz_pend_r) begin
                hi_r <= res_hi_s;
                lo_r <= res_lo_s;
            end else begin
                hi_r <= hi_r;
                lo_r <= lo_r;
            end
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign div_zero = div_zero_r;
    assign hi       = hi_r;
    assign lo       = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit; expectations follow MULTDIV_DIVZERO_EXC_EN when defined.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_zero;

    int checks = 0;
    int errors = 0;

    mult_div_unit dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full 33-cycle operation with operand scrambling after the accept edge
    task automatic do_op(input string tag, input logic o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] ex_hi, input logic [31:0] ex_lo);
        op = o; a = x; b = y; start = 1'b1;
        tick;
        start = 1'b0; op = ~o; a = 32'hDEAD_BEEF; b = 32'h0000_0003;
        tick;
        chk1({tag, " busy@1"}, busy, 1'b1);
        repeat (30) tick;
        tick;
        chk1({tag, " busy@32"}, busy, 1'b1);
        chk1({tag, " done@32"}, done, 1'b0);
        tick;
        chk1({tag, " done@33"}, done, 1'b1);
        chk1({tag, " busy@33"}, busy, 1'b0);
        chk1({tag, " dz@33"}, div_zero, 1'b0);
        chk32({tag, " hi"}, hi, ex_hi);
        chk32({tag, " lo"}, lo, ex_lo);
        tick;
        chk1({tag, " done@34"}, done, 1'b0);
        chk32({tag, " hi hold"}, hi, ex_hi);
        chk32({tag, " lo hold"}, lo, ex_lo);
    endtask

    initial begin
        int done_seen;
        reset = 1'b1; start = 1'b1; op = 1'b0; a = 32'd7; b = 32'd9;
        tick;
        tick;
        chk1("rst busy", busy, 1'b0);
        chk1("rst done", done, 1'b0);
        chk1("rst dz", div_zero, 1'b0);
        chk32("rst hi", hi, 32'd0);
        chk32("rst lo", lo, 32'd0);
        start = 1'b0;
        reset = 1'b0;
        tick;
        chk1("post rst busy", busy, 1'b0);

        do_op("mul 7*-3", 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        do_op("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_op("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        do_op("mul min*min", 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        do_op("div 100/7", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14);
        do_op("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
        do_op("mul max*max", 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001);
        do_op("mul -1*-1", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);

`ifdef MULTDIV_DIVZERO_EXC_EN
        op = 1'b1; a = 32'd5; b = 32'd0; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        chk1("dz done@1", done, 1'b1);
        chk1("dz flag@1", div_zero, 1'b1);
        chk1("dz busy@1", busy, 1'b0);
        chk32("dz hi kept", hi, 32'h0000_0000);
        chk32("dz lo kept", lo, 32'h0000_0001);
        tick;
        chk1("dz done@2", done, 1'b0);
        chk1("dz flag@2", div_zero, 1'b0);
`else
        do_op("div 5/0", 1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
        do_op("div -5/0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'h0000_0001);
`endif

        // Reset in the middle of a multiply aborts it
        op = 1'b0; a = 32'd3; b = 32'd4; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (9) tick;
        chk1("abort busy@9", busy, 1'b1);
        reset = 1'b1;
        tick;
        chk1("abort busy@10", busy, 1'b0);
        chk32("abort hi", hi, 32'd0);
        chk32("abort lo", lo, 32'd0);
        reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick;
            if (done === 1'b1) done_seen++;
        end
        chk32("abort no done", done_seen, 32'd0);
        chk32("abort hi kept", hi, 32'd0);

        // Ignored start while busy, then back-to-back start in FINISH
        op = 1'b0; a = 32'd6; b = 32'd7; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (4) tick;
        op = 1'b1; a = 32'd1; b = 32'd1; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (26) tick;
        tick;
        chk1("b2b busy@32", busy, 1'b1);
        op = 1'b1; a = 32'hFFFF_FFF9; b = 32'd2; start = 1'b1;
        tick;
        start = 1'b0; a = 32'd0; b = 32'd0;
        chk1("b2b done1", done, 1'b1);
        chk32("b2b hi1", hi, 32'd0);
        chk32("b2b lo1", lo, 32'd42);
        tick;
        chk1("b2b no gap busy", busy, 1'b1);
        chk1("b2b done off", done, 1'b0);
        repeat (30) tick;
        tick;
        chk1("b2b busy@65", busy, 1'b1);
        chk1("b2b done@65", done, 1'b0);
        tick;
        chk1("b2b done2", done, 1'b1);
        chk32("b2b hi2", hi, 32'hFFFF_FFFF);
        chk32("b2b lo2", lo, 32'hFFFF_FFFD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have no parameters; all datapaths SHALL be fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  single-cycle request from the control FSM to begin an operation.
REQ-005 op  input  1  operation select: 0 = signed multiply (mult), 1 = signed divide (div).
REQ-006 a  input  32  operand A, driven from register A output; dividend for div.
REQ-007 b  input  32  operand B, driven from register B output; divisor for div.
REQ-008 busy  output  1  high while an operation is iterating.
REQ-009 done  output  1  one-cycle pulse on the cycle hi/lo first show a new result.
REQ-010 hi  output  32  Hi register: upper product half (mult) or remainder (div).
REQ-011 lo  output  32  Lo register: lower product half (mult) or quotient (div).
REQ-012 div_zero  output  1  one-cycle divide-by-zero exception pulse to the control FSM.

Function
REQ-013 The FSM SHALL have states IDLE, MULT, DIV and FINISH.
REQ-014 start SHALL be sampled only in IDLE and FINISH; in MULT or DIV it SHALL be ignored.
REQ-015 On an accepted start, a, b and op SHALL be latched internally; later operand changes SHALL have no effect.
REQ-016 mult SHALL use radix-2 Booth recoding over exactly 32 iteration cycles (MULT), then 1 cycle in FINISH.
REQ-017 div SHALL use restoring division on operand magnitudes over exactly 32 iteration cycles (DIV), then 1 cycle in FINISH applying sign correction.
REQ-018 If start is accepted at edge N, busy SHALL be 1 from edge N+1 through edge N+32, and SHALL be 0 otherwise.
REQ-019 hi/lo SHALL load the result and done SHALL be 1 at edge N+33, for exactly one cycle.
REQ-020 hi/lo SHALL hold their value at all times except REQ-019 and reset.
REQ-021 mult results: {hi,lo} = signed 64-bit product of a and b.
REQ-022 div results: lo = quotient truncated toward zero; hi = remainder with sign of the dividend.
REQ-023 0x80000000 div 0xFFFFFFFF SHALL give lo = 0x80000000 (wrap) and hi = 0; no flag.
REQ-024 0x80000000 mult 0x80000000 SHALL give hi = 0x40000000 and lo = 0x00000000.
REQ-025 A start accepted in FINISH SHALL begin the next operation with no idle gap; busy SHALL be 1 from the following edge.

Reset
REQ-026 While reset is 1 at a clock edge: state = IDLE, hi = lo = 0, busy = done = div_zero = 0, and start SHALL be ignored.
REQ-027 Reset during MULT or DIV SHALL abort the operation; no done pulse and no hi/lo update SHALL follow.

Configuration
REQ-028 Macro MULTDIV_DIVZERO_EXC_EN, when defined: a div accepted with b = 0 SHALL skip iteration.
REQ-029 In that case the FSM SHALL go to FINISH, and div_zero and done SHALL both be 1 at the next edge for exactly one cycle.
REQ-030 In that case hi/lo SHALL be unchanged.
REQ-031 Macro undefined: div_zero SHALL be tied to 0, and division by zero SHALL run the full 33 cycles.
REQ-032 In that case, at the done edge, hi = a, and lo = 0xFFFFFFFF if a >= 0, else 0x00000001.

Verification
REQ-033 mult, a=7, b=-3, start at edge 0 -> busy 1..32, done at edge 33, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-034 div, a=-7, b=2 -> at edge 33: lo=0xFFFFFFFD, hi=0xFFFFFFFF; 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-035 div, a=5, b=0 -> with macro: div_zero=done=1 at edge 1, hi/lo unchanged; without macro: edge 33, hi=5, lo=0xFFFFFFFF.
REQ-036 mult 3*4 started; reset asserted at edge 10 -> no done pulse; hi=lo=0; busy=0 from edge 10.
REQ-037 start pulsed at edge 5 during busy, then a new start in the FINISH cycle -> first result unaffected; second done exactly 33 cycles after FINISH.
